// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and bit-timing helper
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Clock cycles per bit period (integer division, truncating)
    function automatic int calc_bit_cycles(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period clock-enable generator
module uart_baud_gen #(
    parameter int BIT_CYCLES = 104
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic bit_tick
);

    localparam int CNT_W = $clog2(BIT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    assign bit_tick = enable && (count == LAST);

    // Count 0..BIT_CYCLES-1; clear restarts the period so timing follows the caller's anchor
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= bit_tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with valid/ready byte input
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 1000000,
    parameter int BAUD_RATE  = 9600,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int BIT_CYCLES = calc_bit_cycles(CLK_FREQ, BAUD_RATE);
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    if (BIT_CYCLES < 2) begin : g_bad_bit_cycles
        $fatal(1, "uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $fatal(1, "uart_tx: STOP_BITS must be 1 or 2");
    end

    uart_state_t state;
    uart_state_t state_next;
    logic [7:0]  shift;
    logic [2:0]  bit_cnt;
    logic        par_bit;
    logic        tx_next;
    logic        done_next;
    logic        accept;
    logic        bit_tick;

    assign tx_ready = (state == IDLE) && !rst;
    assign accept   = tx_valid && tx_ready;
    assign busy     = (state != IDLE);

    uart_baud_gen #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_baud_gen (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .enable  (busy),
        .bit_tick(bit_tick)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and line level; unknown encodings fall back to IDLE with the line high
    always_comb begin
        state_next = state;
        tx_next    = 1'b1;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = START;
            end
            START: begin
                tx_next = 1'b0;
                if (bit_tick) state_next = DATA;
            end
            DATA: begin
                tx_next = shift[0];
                if (bit_tick && bit_cnt == DATA_LAST) begin
                    state_next = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                tx_next = par_bit;
                if (bit_tick) state_next = STOP;
            end
            STOP: begin
                tx_next = 1'b1;
                if (bit_tick && bit_cnt == STOP_LAST) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch byte on accept, shift per data bit, count data/stop bits, register line and done
    always_ff @(posedge clk) begin
        if (rst) begin
            shift   <= '0;
            bit_cnt <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            done    <= 1'b0;
        end else begin
            tx   <= tx_next;
            done <= done_next;
            if (accept) begin
                shift   <= tx_data;
                par_bit <= (^tx_data) ^ PAR_ODD;
                bit_cnt <= '0;
            end else if (bit_tick) begin
                if (state == DATA) begin
                    shift   <= shift >> 1;
                    bit_cnt <= bit_cnt + 3'd1;
                end else if (state == STOP) begin
                    bit_cnt <= done_next ? 3'd0 : bit_cnt + 3'd1;
                end
            end
        end
    end

endmodule
